// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the byte-serial memory controller.
package mem_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int BYTE_W = 8;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [BYTE_W-1:0] byte_t;

    localparam logic [2:0] LEN_B = 3'd1;
    localparam logic [2:0] LEN_H = 3'd2;
    localparam logic [2:0] LEN_W = 3'd4;

    typedef enum logic [1:0] {
        MC_IDLE  = 2'd0,
        MC_READ  = 2'd1,
        MC_WRITE = 2'd2,
        MC_DONE  = 2'd3
    } mc_state_t;

    // Any length other than byte or half is served as a full word.
    function automatic logic [2:0] norm_len(input logic [2:0] len);
        return (len == LEN_B || len == LEN_H) ? len : LEN_W;
    endfunction

endpackage

// File: rtl/mem_ctrl_if.sv
// Pipeline request ports and 8-bit RAM/IO bus of the memory controller.
interface mem_ctrl_if;
    import mem_ctrl_pkg::*;

    // Handshake: a requester raises req (level) with stable fields and holds it
    // until its done pulses for exactly one cycle; data is valid in that cycle.
    logic       if_req_in;
    addr_t      if_addr_in;
    logic       if_done_out;
    data_t      if_inst_out;

    logic       ls_req_in;
    logic       ls_we_in;
    logic [2:0] ls_len_in;
    addr_t      ls_addr_in;
    data_t      ls_wdata_in;
    logic       ls_done_out;
    data_t      ls_rdata_out;

    byte_t      ram_din_in;
    byte_t      ram_dout_out;
    addr_t      ram_a_out;
    logic       ram_wr_out;
    logic       busy_out;

    modport slave (
        input  if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_len_in,
               ls_addr_in, ls_wdata_in, ram_din_in,
        output if_done_out, if_inst_out, ls_done_out, ls_rdata_out,
               ram_dout_out, ram_a_out, ram_wr_out, busy_out
    );

    modport master (
        output if_req_in, if_addr_in, ls_req_in, ls_we_in, ls_len_in,
               ls_addr_in, ls_wdata_in, ram_din_in,
        input  if_done_out, if_inst_out, ls_done_out, ls_rdata_out,
               ram_dout_out, ram_a_out, ram_wr_out, busy_out
    );

endinterface

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller: arbitrates fetch and load/store requests
// onto the 8-bit RAM/IO bus, with a 2-cycle read turnaround.
module mem_ctrl
    import mem_ctrl_pkg::*;
(
    input  logic      clk_in,
    input  logic      rst_in,
    input  logic      rdy_in,
    mem_ctrl_if.slave bus,
    output mc_state_t dbg_state_out
);

    mc_state_t  state_q;
    logic       is_ls_q;
    logic [2:0] len_q;
    logic [2:0] cnt_q;
    data_t      asm_q;
    data_t      asm_d;
    addr_t      ram_a_q;
    byte_t      ram_dout_q;
    logic       ram_wr_q;
    logic       if_done_q;
    logic       ls_done_q;
    data_t      if_inst_q;
    data_t      ls_rdata_q;
    byte_t      hold_q;
    logic       frz_q;
    byte_t      cap_byte;
    logic [1:0] byte_idx;
    logic [2:0] ls_len_d;

    // The RAM keeps answering for the held address while frozen, so the byte
    // pending at the first frozen edge is parked in hold_q and used on resume.
    always_comb begin
        cap_byte = frz_q ? hold_q : bus.ram_din_in;
        byte_idx = 2'(cnt_q - 3'd1);
        asm_d    = asm_q;
        asm_d[{byte_idx, 3'b000} +: BYTE_W] = cap_byte;
        ls_len_d = norm_len(bus.ls_len_in);
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            state_q    <= MC_IDLE;
            is_ls_q    <= 1'b0;
            len_q      <= '0;
            cnt_q      <= '0;
            asm_q      <= '0;
            ram_a_q    <= '0;
            ram_dout_q <= '0;
            ram_wr_q   <= 1'b0;
            if_done_q  <= 1'b0;
            ls_done_q  <= 1'b0;
            if_inst_q  <= '0;
            ls_rdata_q <= '0;
            hold_q     <= '0;
            frz_q      <= 1'b0;
        end else begin
            frz_q <= ~rdy_in;
            if (!rdy_in && !frz_q) hold_q <= bus.ram_din_in;
            if (rdy_in) begin
                case (state_q)
                    MC_IDLE: begin
                        if (bus.ls_req_in) begin
                            is_ls_q <= 1'b1;
                            len_q   <= ls_len_d;
                            ram_a_q <= bus.ls_addr_in;
                            cnt_q   <= '0;
                            if (bus.ls_we_in) begin
                                asm_q      <= bus.ls_wdata_in;
                                ram_dout_q <= bus.ls_wdata_in[7:0];
                                ram_wr_q   <= 1'b1;
                                state_q    <= MC_WRITE;
                            end else begin
                                asm_q   <= '0;
                                state_q <= MC_READ;
                            end
                        end else if (bus.if_req_in) begin
                            is_ls_q <= 1'b0;
                            len_q   <= LEN_W;
                            ram_a_q <= bus.if_addr_in;
                            cnt_q   <= '0;
                            asm_q   <= '0;
                            state_q <= MC_READ;
                        end
                    end
                    // cnt_q is the cycle index i after acceptance: address i is
                    // issued while byte i-1 arrives; the last cycle only captures.
                    MC_READ: begin
                        if (cnt_q != 3'd0) asm_q <= asm_d;
                        if (cnt_q + 3'd1 < len_q) ram_a_q <= ram_a_q + addr_t'(1);
                        if (cnt_q == len_q) begin
                            state_q <= MC_DONE;
                            if (is_ls_q) begin
                                ls_done_q  <= 1'b1;
                                ls_rdata_q <= asm_d;
                            end else begin
                                if_done_q <= 1'b1;
                                if_inst_q <= asm_d;
                            end
                        end
                        cnt_q <= cnt_q + 3'd1;
                    end
                    MC_WRITE: begin
                        if (cnt_q + 3'd1 == len_q) begin
                            ram_wr_q  <= 1'b0;
                            ls_done_q <= 1'b1;
                            state_q   <= MC_DONE;
                        end else begin
                            ram_a_q    <= ram_a_q + addr_t'(1);
                            ram_dout_q <= asm_q[15:8];
                            asm_q      <= asm_q >> BYTE_W;
                            cnt_q      <= cnt_q + 3'd1;
                        end
                    end
                    MC_DONE: begin
                        if_done_q <= 1'b0;
                        ls_done_q <= 1'b0;
                        state_q   <= MC_IDLE;
                    end
                    default: state_q <= MC_IDLE;
                endcase
            end
        end
    end

    assign bus.ram_a_out    = ram_a_q;
    assign bus.ram_dout_out = ram_dout_q;
    assign bus.ram_wr_out   = ram_wr_q & rdy_in;
    assign bus.if_done_out  = if_done_q;
    assign bus.if_inst_out  = if_inst_q;
    assign bus.ls_done_out  = ls_done_q;
    assign bus.ls_rdata_out = ls_rdata_q;
    assign bus.busy_out     = (state_q != MC_IDLE);
    assign dbg_state_out    = state_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Self-checking bench for mem_ctrl: byte-addressed RAM model, directed cases,
// then randomized fetch/load/store traffic with freezes and contention.
module tb_mem_ctrl;
    import mem_ctrl_pkg::*;

    logic      clk = 1'b0;
    logic      rst_n;
    logic      rdy;
    mc_state_t dbg_state;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [7:0]  mem [logic [31:0]];
    logic [31:0] exp_q[$];
    logic [31:0] a_log[$];
    logic [31:0] wr_a_log[$];
    logic [7:0]  wr_d_log[$];

    mem_ctrl_if bus();

    mem_ctrl dut (
        .clk_in       (clk),
        .rst_in       (rst_n),
        .rdy_in       (rdy),
        .bus          (bus),
        .dbg_state_out(dbg_state)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    function automatic logic [7:0] mval(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a[7:0] ^ a[15:8] ^ 8'h5c;
    endfunction

    function automatic int nrm(input logic [2:0] len);
        return (len == 3'd1 || len == 3'd2) ? int'(len) : 4;
    endfunction

    function automatic logic [31:0] pick_addr();
        case ($urandom_range(0, 3))
            0:       return 32'h0000_1000 + 32'($urandom_range(0, 31));
            1:       return 32'hFFFF_FFFC + 32'($urandom_range(0, 3));
            2:       return 32'h0003_0000 + 32'($urandom_range(0, 7));
            default: return $urandom();
        endcase
    endfunction

    // RAM answers for the address driven in the previous cycle.
    always @(posedge clk) bus.ram_din_in <= mval(bus.ram_a_out);

    always @(negedge clk) begin
        #1;
        if (bus.ram_wr_out) begin
            mem[bus.ram_a_out] = bus.ram_dout_out;
            wr_a_log.push_back(bus.ram_a_out);
            wr_d_log.push_back(bus.ram_dout_out);
        end
        if (dbg_state == MC_READ || dbg_state == MC_WRITE) begin
            if (a_log.size() == 0 || a_log[$] != bus.ram_a_out)
                a_log.push_back(bus.ram_a_out);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit do_if, input logic [31:0] ia,
                           input bit do_ls, input bit we, input logic [2:0] len,
                           input logic [31:0] la, input logic [31:0] wd);
        bus.if_req_in   = do_if;
        bus.if_addr_in  = ia;
        bus.ls_req_in   = do_ls;
        bus.ls_we_in    = we;
        bus.ls_len_in   = len;
        bus.ls_addr_in  = la;
        bus.ls_wdata_in = wd;
    endtask

    // Called at a negedge where the DUT is about to accept this request.
    task automatic serve(input bit is_ls, input bit we, input logic [2:0] len,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int frz_at, input int frz_len);
        int          n, lat_exp, t0, steps, lat;
        logic [31:0] exp_d, got_d, ref_a;
        bit          done, other, busy_at;
        n = is_ls ? nrm(len) : 4;
        exp_d = '0;
        exp_q.delete();
        for (int i = 0; i < n; i++) begin
            exp_q.push_back(a + 32'(i));
            if (!we) exp_d[8*i +: 8] = mval(a + 32'(i));
        end
        lat_exp = (we ? n + 1 : n + 2) + frz_len;
        a_log.delete();
        wr_a_log.delete();
        wr_d_log.delete();
        t0 = cyc; done = 0; other = 0; steps = 0; lat = -1;
        ref_a = '0; got_d = '0; busy_at = 0;
        while (!done && steps < 60) begin
            @(negedge clk);
            steps = cyc - t0;
            if (is_ls ? bus.if_done_out : bus.ls_done_out) other = 1;
            if (is_ls ? bus.ls_done_out : bus.if_done_out) begin
                done    = 1;
                lat     = steps;
                got_d   = is_ls ? bus.ls_rdata_out : bus.if_inst_out;
                busy_at = bus.busy_out;
            end else if (frz_len > 0) begin
                if (steps > frz_at && steps <= frz_at + frz_len) begin
                    check("frz_wr", 32'(bus.ram_wr_out), 32'd0);
                    check("frz_addr", bus.ram_a_out, ref_a);
                end
                if (steps == frz_at) begin
                    ref_a = bus.ram_a_out;
                    rdy   = 1'b0;
                end
                if (steps == frz_at + frz_len) rdy = 1'b1;
            end
        end
        rdy = 1'b1;
        check("done_seen", 32'(done), 32'd1);
        check("latency", 32'(lat), 32'(lat_exp));
        check("busy_in_done", 32'(busy_at), 32'd1);
        check("other_done", 32'(other), 32'd0);
        if (!we) check("rdata", got_d, exp_d);
        if (is_ls) bus.ls_req_in = 1'b0;
        else       bus.if_req_in = 1'b0;
        @(negedge clk);
        check("pulse_len", 32'(is_ls ? bus.ls_done_out : bus.if_done_out), 32'd0);
        check("held_data", is_ls && we ? 32'd0 : (is_ls ? bus.ls_rdata_out : bus.if_inst_out),
              is_ls && we ? 32'd0 : exp_d);
        check("addr_count", 32'(a_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < a_log.size() && i < exp_q.size(); i++)
            check("addr_seq", a_log[i], exp_q[i]);
        check("wr_count", 32'(wr_a_log.size()), we ? 32'(n) : 32'd0);
        for (int i = 0; i < wr_a_log.size() && i < n && we; i++) begin
            check("wr_addr", wr_a_log[i], a + 32'(i));
            check("wr_data", 32'(wr_d_log[i]), 32'(wd[8*i +: 8]));
        end
    endtask

    initial begin
        bit          seen;
        int          kind, fa, fl, nf;
        bit          we;
        logic [2:0]  len;
        logic [31:0] la, ia, wd;

        rst_n = 1'b0;
        rdy   = 1'b1;
        set_req(0, '0, 0, 0, '0, '0, '0);
        repeat (3) @(negedge clk);
        check("rst_ram_a", bus.ram_a_out, 32'd0);
        check("rst_ram_wr", 32'(bus.ram_wr_out), 32'd0);
        check("rst_ram_dout", 32'(bus.ram_dout_out), 32'd0);
        check("rst_if_done", 32'(bus.if_done_out), 32'd0);
        check("rst_ls_done", 32'(bus.ls_done_out), 32'd0);
        check("rst_if_inst", bus.if_inst_out, 32'd0);
        check("rst_ls_rdata", bus.ls_rdata_out, 32'd0);
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(MC_IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Fetch of a known instruction word.
        mem[32'h10] = 8'h13; mem[32'h11] = 8'h00; mem[32'h12] = 8'h00; mem[32'h13] = 8'h93;
        set_req(1, 32'h10, 0, 0, '0, '0, '0);
        serve(0, 0, 3'd4, 32'h10, '0, 0, 0);
        check("fetch_word", bus.if_inst_out, 32'h9300_0013);

        // Simultaneous requests: load wins, fetch follows.
        mem[32'h104] = 8'hAA; mem[32'h105] = 8'hBB;
        set_req(1, 32'h20, 1, 0, 3'd2, 32'h104, '0);
        serve(1, 0, 3'd2, 32'h104, '0, 0, 0);
        check("tie_ls_rdata", bus.ls_rdata_out, 32'h0000_BBAA);
        serve(0, 0, 3'd4, 32'h20, '0, 0, 0);

        // Word store.
        set_req(0, '0, 1, 1, 3'd4, 32'h200, 32'hDEAD_BEEF);
        serve(1, 1, 3'd4, 32'h200, 32'hDEAD_BEEF, 0, 0);
        check("store_b3", 32'(mval(32'h203)), 32'h0000_00DE);

        // Fetch frozen for 3 cycles after byte 1 arrives.
        set_req(1, 32'h10, 0, 0, '0, '0, '0);
        serve(0, 0, 3'd4, 32'h10, '0, 4, 3);
        check("frz_word", bus.if_inst_out, 32'h9300_0013);

        // Single-byte IO load.
        mem[32'h30000] = 8'hC7;
        set_req(0, '0, 1, 0, 3'd1, 32'h30000, '0);
        serve(1, 0, 3'd1, 32'h30000, '0, 0, 0);
        check("io_load", bus.ls_rdata_out, 32'h0000_00C7);

        // Reset during a store, after bytes 0 and 1 were written.
        wr_a_log.delete();
        wr_d_log.delete();
        set_req(0, '0, 1, 1, 3'd4, 32'h300, 32'h1122_3344);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_wr", 32'(bus.ram_wr_out), 32'd0);
        check("midrst_busy", 32'(bus.busy_out), 32'd0);
        bus.ls_req_in = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (4) begin
            @(negedge clk);
            if (bus.ls_done_out) seen = 1;
        end
        check("midrst_no_done", 32'(seen), 32'd0);
        check("midrst_wr_cnt", 32'(wr_a_log.size()), 32'd2);
        set_req(0, '0, 1, 0, 3'd4, 32'h300, '0);
        serve(1, 0, 3'd4, 32'h300, '0, 0, 0);
        check("midrst_partial", {16'd0, bus.ls_rdata_out[15:0]}, 32'h0000_3344);

        // Fetch across the top of the address space.
        set_req(1, 32'hFFFF_FFFE, 0, 0, '0, '0, '0);
        serve(0, 0, 3'd4, 32'hFFFF_FFFE, '0, 0, 0);

        for (int t = 0; t < 40; t++) begin
            kind = $urandom_range(0, 3);
            la   = pick_addr();
            ia   = pick_addr();
            len  = 3'($urandom_range(0, 7));
            we   = 1'($urandom_range(0, 1));
            wd   = $urandom();
            nf   = (kind == 0) ? 4 : nrm(len);
            fl   = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : 0;
            fa   = $urandom_range(1, nf);
            case (kind)
                0: begin
                    set_req(1, ia, 0, 0, '0, '0, '0);
                    serve(0, 0, 3'd4, ia, '0, fa, fl);
                end
                3: begin
                    set_req(1, ia, 1, we, len, la, wd);
                    serve(1, we, len, la, wd, fa, fl);
                    serve(0, 0, 3'd4, ia, '0, 0, 0);
                end
                default: begin
                    set_req(0, '0, 1, we, len, la, wd);
                    serve(1, we, len, la, wd, fa, fl);
                end
            endcase
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
